// File: rtl/cache_refill_unit_pkg.sv
// Shared cache/refill definitions: line geometry defaults, refill FSM states
// and the latched miss-request record.
package cache_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int LINE_BYTES_DEF = 4;

  function automatic int off_w(input int line_bytes);
    return (line_bytes > 1) ? $clog2(line_bytes) : 1;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    WB_READ,
    WB_WRITE,
    FILL_REQ,
    FILL_WAIT,
    DONE
  } refill_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]                fill_addr;
    logic                                 wb;
    logic [ADDR_W_DEF-1:0]                wb_addr;
    logic [off_w(LINE_BYTES_DEF)-1:0]     crit_off;
  } refill_req_t;

endpackage

// File: rtl/cache_refill_unit_ofs_counter.sv
// Byte-offset counter for one line transfer, with last-byte flag and the
// fill order offset (critical-byte-first when CACHE_REFILL_CRIT_FIRST_EN).
module refill_ofs_counter
  import cache_pkg::*;
#(
  parameter  int LINE_BYTES = LINE_BYTES_DEF,
  localparam int OFF_W      = off_w(LINE_BYTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [OFF_W-1:0] crit_off,
  output logic [OFF_W-1:0] cnt,
  output logic [OFF_W-1:0] ord,
  output logic             last
);

  logic [OFF_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + OFF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == OFF_W'(LINE_BYTES - 1));

`ifdef CACHE_REFILL_CRIT_FIRST_EN
  // LINE_BYTES is a power of two, so dropping the carry is the modulo
  assign ord = cnt_q + crit_off;
`else
  logic unused_crit_off;
  assign unused_crit_off = ^crit_off;
  assign ord = cnt_q;
`endif

endmodule

// File: rtl/cache_refill_unit.sv
// Cache miss handler: optional dirty-victim write-back, then byte-wise line fill.
// Optional critical-byte-first fill order: CACHE_REFILL_CRIT_FIRST_EN.
//
// state     | meaning
// IDLE      | waiting for a miss request, req_ready high
// WB_READ   | read one victim byte from the cache array
// WB_WRITE  | write that victim byte to memory, held until granted
// FILL_REQ  | issue one fill read to memory, held until granted
// FILL_WAIT | wait for read data, write it into the cache array
// DONE      | one-cycle completion pulse
module cache_refill_unit
  import cache_pkg::*;
#(
  parameter  int ADDR_W     = ADDR_W_DEF,
  parameter  int LINE_BYTES = LINE_BYTES_DEF,
  localparam int OFF_W      = off_w(LINE_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_fill_addr,
  input  logic              req_wb,
  input  logic [ADDR_W-1:0] req_wb_addr,
  input  logic [OFF_W-1:0]  req_crit_off,
  output logic              wb_rd_en,
  output logic [OFF_W-1:0]  wb_idx,
  input  logic [7:0]        wb_data,
  output logic              fill_we,
  output logic [OFF_W-1:0]  fill_idx,
  output logic [7:0]        fill_data,
  output logic              done,
`ifdef CACHE_REFILL_CRIT_FIRST_EN
  output logic              crit_valid,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

  refill_state_e    state_q, state_d;
  refill_req_t      req_q, req_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             wb_first_q, wb_first_d;

  logic             cnt_clr, cnt_inc, cnt_last;
  logic [OFF_W-1:0] cnt, ord;

  refill_ofs_counter #(
    .LINE_BYTES (LINE_BYTES)
  ) u_ofs (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .crit_off (req_q.crit_off),
    .cnt      (cnt),
    .ord      (ord),
    .last     (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    wdata_d    = wdata_q;
    wb_first_d = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    req_ready  = 1'b0;
    wb_rd_en   = 1'b0;
    wb_idx     = '0;
    fill_we    = 1'b0;
    fill_idx   = '0;
    fill_data  = '0;
    done       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d.fill_addr = req_fill_addr & LINE_MASK;
          req_d.wb_addr   = req_wb_addr & LINE_MASK;
          req_d.wb        = req_wb;
          req_d.crit_off  = req_crit_off;
          cnt_clr         = 1'b1;
          state_d         = req_wb ? WB_READ : FILL_REQ;
        end
      end

      WB_READ: begin
        wb_rd_en   = req_q.wb;
        wb_idx     = cnt;
        wb_first_d = 1'b1;
        state_d    = WB_WRITE;
      end

      WB_WRITE: begin
        // wb_data is only valid in the first cycle; later cycles replay the copy
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = req_q.wb_addr | ADDR_W'(cnt);
        mem_wdata = wb_first_q ? wb_data : wdata_q;
        if (wb_first_q) begin
          wdata_d = wb_data;
        end
        if (mem_gnt) begin
          if (cnt_last) begin
            cnt_clr = 1'b1;
            state_d = FILL_REQ;
          end else begin
            cnt_inc = 1'b1;
            state_d = WB_READ;
          end
        end
      end

      FILL_REQ: begin
        mem_req  = 1'b1;
        mem_addr = req_q.fill_addr | ADDR_W'(ord);
        if (mem_gnt) begin
          state_d = FILL_WAIT;
        end
      end

      FILL_WAIT: begin
        fill_we   = mem_rvalid;
        fill_idx  = ord;
        fill_data = mem_rdata;
        if (mem_rvalid) begin
          if (cnt_last) begin
            state_d = DONE;
          end else begin
            cnt_inc = 1'b1;
            state_d = FILL_REQ;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef CACHE_REFILL_CRIT_FIRST_EN
  assign crit_valid = fill_we && (cnt == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= '0;
      wdata_q    <= '0;
      wb_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      wdata_q    <= wdata_d;
      wb_first_q <= wb_first_d;
    end
  end

endmodule

// File: doc/cache_refill_unit.md
Name: cache_refill_unit

Overview:
- Miss-handling stage directly downstream of the byte-wide set-associative cache.
- Accepts one line-miss request at a time from the cache.
- If the victim line is dirty, writes it back byte-by-byte to backing memory, then fetches the missing line byte-by-byte and writes each byte into the cache data array.
- Pulses completion so the cache can retry the stalled access.

Parameters:
- ADDR_W, 16, byte address width shared with the cache.
- LINE_BYTES, 4, bytes per cache line (matches cache cache_line); power of two, ≥2.
- OFF_W, $clog2(LINE_BYTES), localparam, line-offset width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  cache has a miss to service.
- req_ready  out  1  unit idle, can accept a request.
- req_fill_addr  in  ADDR_W  missing line address; low OFF_W bits ignored.
- req_wb  in  1  victim line dirty, write back first.
- req_wb_addr  in  ADDR_W  victim line address; low OFF_W bits ignored.
- req_crit_off  in  OFF_W  offset of the stalled byte (used only with the option).
- wb_rd_en  out  1  read one victim byte from the cache array.
- wb_idx  out  OFF_W  victim byte offset.
- wb_data  in  8  victim byte, valid the cycle after wb_rd_en.
- fill_we  out  1  write one byte into the cache array.
- fill_idx  out  OFF_W  fill byte offset.
- fill_data  out  8  fill byte.
- done  out  1  one-cycle pulse: line complete.
- mem_req  out  1  memory request, held until granted.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  8  read data.

Behaviour:
- Reset (async, rst_n=0): state IDLE, offset counter 0, latched addresses 0. All outputs 0 except req_ready=1.
- Reset mid-operation: aborts immediately; no done is issued. The cache must treat the in-flight line as invalid.
- States: IDLE, WB_READ, WB_WRITE, FILL_REQ, FILL_WAIT, DONE.
- IDLE:
  - req_ready=1 in IDLE only.
  - On req_valid&&req_ready, latch both line addresses with the offset bits forced to 0, and latch req_wb and req_crit_off.
  - Clear the counter, then go to WB_READ if req_wb else FILL_REQ.
- WB_READ: wb_rd_en=1, wb_idx=cnt for exactly one cycle, then go to WB_WRITE.
- WB_WRITE:
  - First cycle: register wb_data into mem_wdata.
  - mem_req=1, mem_we=1, mem_addr=wb_line|cnt, held stable until mem_gnt.
  - On gnt: if cnt==LINE_BYTES-1, clear cnt and go to FILL_REQ; else cnt+1 and go to WB_READ.
- FILL_REQ: mem_req=1, mem_we=0, mem_addr=fill_line|ord(cnt), held until mem_gnt, then go to FILL_WAIT.
- FILL_WAIT:
  - fill_we = mem_rvalid (combinational); fill_idx=ord(cnt); fill_data=mem_rdata.
  - On rvalid: if cnt==LINE_BYTES-1, go to DONE; else cnt+1 and go to FILL_REQ.
- DONE: done=1 for one cycle, then go to IDLE. The next request is accepted the following cycle earliest.
- ord(cnt)=cnt (offset arithmetic modulo LINE_BYTES, wraps silently).
- Ignored inputs:
  - mem_gnt while mem_req=0.
  - mem_rvalid outside FILL_WAIT.
  - req_valid outside IDLE.
  - Only one memory transaction outstanding at any time.
- mem_gnt and mem_rvalid in the same FILL_REQ cycle: rvalid ignored (the data belongs to no request).
- Zero-wait memory timing (gnt in the request cycle, rvalid the next cycle):
  - Each byte costs 2 cycles.
  - Clean miss, LINE_BYTES=4: accept at T0, fill_we at T2/T4/T6/T8, done at T9.
  - Dirty miss adds 8 cycles.

Optional Feature:
- Macro: CACHE_REFILL_CRIT_FIRST_EN.
- Defined: ord(cnt)=(crit_off+cnt) mod LINE_BYTES, so the fill starts at the stalled byte and wraps. An extra output crit_valid pulses together with the first fill_we.
- Undefined: ord(cnt)=cnt; req_crit_off is ignored; crit_valid is absent.
- Write-back order is 0..LINE_BYTES-1 in both cases.

Decomposition:
- Shared package cache_pkg holds:
  - LINE_BYTES and ADDR_W defaults, shared with the cache.
  - OFF_W function.
  - refill_state_e enum.
  - refill_req_t struct {fill_addr, wb, wb_addr, crit_off}.
- One sub-module is natural: refill_ofs_counter (count, last flag, wrap offset for the option).

Test Plan:
- Clean miss, req_fill_addr=0x1236, zero-wait memory -> mem reads 0x1234..0x1237; fill_idx 0,1,2,3 with returned data; done at T9; req_ready low T1..T9.
- Dirty miss, wb_addr=0x0040, cache bytes AA,BB,CC,DD, fill 0x0080 -> 4 writes to 0x40..0x43 with AA..DD, then 4 reads from 0x80..0x83; done at T17.
- mem_gnt delayed 3 cycles on each request -> mem_req/mem_addr/mem_we/mem_wdata held stable; byte order unchanged; done delayed 12 cycles.
- rst_n pulled low during the second fill byte -> all outputs 0 asynchronously, req_ready=1, no done; new request after release services normally.
- Spurious mem_rvalid in IDLE and WB_WRITE, plus req_valid while busy -> no fill_we, request not accepted until DONE has passed.
- With CACHE_REFILL_CRIT_FIRST_EN, req_crit_off=2 -> fill_idx order 2,3,0,1; crit_valid with first fill_we only.
